// File: rtl/maxpool2x2_stream_if.sv
// Pixel-stream and pooled-result bundle for maxpool2x2_stream.
// The master drives pixels and reads pooled beats; the slave is the pooling stage.
interface maxpool2x2_stream_if #(
  parameter int unsigned DW = 12
);
  logic          valid_in;
  logic          sof_in;
  logic [DW-1:0] conv_in_1;
  logic [DW-1:0] conv_in_2;
  logic [DW-1:0] conv_in_3;
  logic [DW-1:0] max_value_1;
  logic [DW-1:0] max_value_2;
  logic [DW-1:0] max_value_3;
  logic          valid_out;
  logic          frame_done;

  modport master (
    output valid_in, sof_in, conv_in_1, conv_in_2, conv_in_3,
    input  max_value_1, max_value_2, max_value_3, valid_out, frame_done
  );

  modport slave (
    input  valid_in, sof_in, conv_in_1, conv_in_2, conv_in_3,
    output max_value_1, max_value_2, max_value_3, valid_out, frame_done
  );
endinterface

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 max-pool over three signed channels, one half-width line buffer each.
// Optional input ReLU clamp is enabled by defining MAXPOOL_RELU_EN.
module maxpool2x2_stream #(
  parameter int unsigned IMG_W = 24,
  parameter int unsigned IMG_H = 24,
  parameter int unsigned DW    = 12
) (
  input logic                clk,
  input logic                rst_n,
  maxpool2x2_stream_if.slave io_pool
);

  localparam int unsigned LbDepth = IMG_W / 2;
  localparam int unsigned CW      = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW      = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int unsigned LW      = (LbDepth > 1) ? $clog2(LbDepth) : 1;

  if ((IMG_W % 2) != 0) begin : g_bad_w
    $error("maxpool2x2_stream: IMG_W must be even");
  end
  if ((IMG_H % 2) != 0) begin : g_bad_h
    $error("maxpool2x2_stream: IMG_H must be even");
  end

  function automatic logic signed [DW-1:0] clamp(input logic signed [DW-1:0] v);
`ifdef MAXPOOL_RELU_EN
    return v[DW-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [CW-1:0]           r_col, w_col, w_col_nxt;
  logic [RW-1:0]           r_row, w_row, w_row_nxt;
  logic signed [DW-1:0]    r_hold [3];
  logic signed [DW-1:0]    r_max  [3];
  logic                    r_valid_out, r_frame_done;
  logic signed [DW-1:0]    r_lb   [LbDepth][3];

  logic signed [DW-1:0]    w_px   [3];
  logic signed [DW-1:0]    w_pair [3];
  logic signed [DW-1:0]    w_res  [3];
  logic [LW-1:0]           w_lb_idx;
  logic                    w_col_last, w_row_last;
  logic                    w_hold_we, w_lb_we, w_fire, w_last;

  // A start-of-frame beat overrides the counters so the pixel lands at (0,0).
  always_comb begin
    w_col      = io_pool.sof_in ? '0 : r_col;
    w_row      = io_pool.sof_in ? '0 : r_row;
    w_col_last = (w_col == CW'(IMG_W - 1));
    w_row_last = (w_row == RW'(IMG_H - 1));
    w_lb_idx   = LW'(w_col >> 1);

    w_hold_we  = io_pool.valid_in & ~w_col[0];
    w_lb_we    = io_pool.valid_in &  w_col[0] & ~w_row[0];
    w_fire     = io_pool.valid_in &  w_col[0] &  w_row[0];
    w_last     = w_fire & w_col_last & w_row_last;

    w_col_nxt  = r_col;
    w_row_nxt  = r_row;
    if (io_pool.valid_in) begin
      if (w_col_last) begin
        w_col_nxt = '0;
        w_row_nxt = w_row_last ? '0 : w_row + RW'(1);
      end else begin
        w_col_nxt = w_col + CW'(1);
        w_row_nxt = w_row;
      end
    end
  end

  always_comb begin
    w_px[0] = clamp(signed'(io_pool.conv_in_1));
    w_px[1] = clamp(signed'(io_pool.conv_in_2));
    w_px[2] = clamp(signed'(io_pool.conv_in_3));
    for (int ch = 0; ch < 3; ch++) begin
      w_pair[ch] = smax(r_hold[ch], w_px[ch]);
      w_res[ch]  = smax(r_lb[w_lb_idx][ch], w_pair[ch]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col        <= '0;
      r_row        <= '0;
      r_valid_out  <= 1'b0;
      r_frame_done <= 1'b0;
      for (int ch = 0; ch < 3; ch++) begin
        r_hold[ch] <= '0;
        r_max[ch]  <= '0;
      end
    end else begin
      r_col        <= w_col_nxt;
      r_row        <= w_row_nxt;
      r_valid_out  <= w_fire;
      r_frame_done <= w_last;
      for (int ch = 0; ch < 3; ch++) begin
        if (w_hold_we) r_hold[ch] <= w_px[ch];
        if (w_fire)    r_max[ch]  <= w_res[ch];
      end
    end
  end

  // Each entry is written on an even row before the odd row reads it, so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_lb_we) begin
      for (int ch = 0; ch < 3; ch++) begin
        r_lb[w_lb_idx][ch] <= w_pair[ch];
      end
    end
  end

  assign io_pool.max_value_1 = r_max[0];
  assign io_pool.max_value_2 = r_max[1];
  assign io_pool.max_value_3 = r_max[2];
  assign io_pool.valid_out   = r_valid_out;
  assign io_pool.frame_done  = r_frame_done;

endmodule
